// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the fetch/data memory responder.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam int unsigned DATA_W = 32;

  // Misaligned or beyond the last word of the array.
  function automatic logic addr_err(input logic [63:0] addr, input int unsigned depth_words);
    return (addr[1:0] != 2'b00) || (addr >= (64'(depth_words) << 2));
  endfunction

  function automatic logic [31:0] word_idx(input logic [63:0] addr);
    return addr[33:2];
  endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Word storage: writes commit on the accept edge, reads are captured on the accept edge.
// With MEMRESP_BYTE_STROBE_EN defined, writes honour per-byte strobes.
module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_i,
  input  logic              we_i,
  input  logic              err_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
`ifdef MEMRESP_BYTE_STROBE_EN
  input  logic [3:0]        wstrb_i,
`endif
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Errored writes never touch the array; contents survive reset.
  always_ff @(posedge clk) begin
    if (acc_i && we_i && !err_i) begin
`ifdef MEMRESP_BYTE_STROBE_EN
      for (int k = 0; k < 4; k++) begin
        if (wstrb_i[k]) mem_q[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
`else
      mem_q[idx_i] <= wdata_i;
`endif
    end
  end

  // Writes and errored reads return zero data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (acc_i) begin
      rdata_q <= (we_i || err_i) ? '0 : mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder serving a fetch port and a data port, one request at a time.
// Define MEMRESP_BYTE_STROBE_EN to add d_req_wstrb byte-lane write enables.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_rsp_valid,
  output logic [DATA_W-1:0] i_rsp_data,
  output logic              i_rsp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
`ifdef MEMRESP_BYTE_STROBE_EN
  input  logic [3:0]        d_req_wstrb,
`endif
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_rdata,
  output logic              d_rsp_err
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);
  localparam logic SKIP_WAIT = (LATENCY <= 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              owner_q;
  logic              err_q;

  logic              acc_d_c;
  logic              acc_i_c;
  logic              acc_c;
  logic              we_c;
  logic              err_c;
  logic [ADDR_W-1:0] addr_c;
  logic [IDX_W-1:0]  idx_c;
  logic [DATA_W-1:0] rdata;
  logic              rsp_c;

  // Data port wins ties: it carries the older instruction.
  assign d_req_ready = (state_q == IDLE);
  assign i_req_ready = (state_q == IDLE) && !d_req_valid;

  assign acc_d_c = d_req_valid && d_req_ready && !rst;
  assign acc_i_c = i_req_valid && i_req_ready && !rst;
  assign acc_c   = acc_d_c || acc_i_c;
  assign we_c    = acc_d_c && d_req_we;
  assign addr_c  = acc_d_c ? d_req_addr : i_req_addr;
  assign err_c   = addr_err(64'(addr_c), DEPTH_WORDS);
  assign idx_c   = IDX_W'(word_idx(64'(addr_c)));

  mem_responder_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .acc_i   (acc_c),
    .we_i    (we_c),
    .err_i   (err_c),
    .idx_i   (idx_c),
    .wdata_i (d_req_wdata),
`ifdef MEMRESP_BYTE_STROBE_EN
    .wstrb_i (d_req_wstrb),
`endif
    .rdata_o (rdata)
  );

  // Request/latency/response sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= REQ_I;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc_c) begin
            owner_q <= acc_d_c ? REQ_D : REQ_I;
            err_q   <= err_c;
            cnt_q   <= '0;
            state_q <= SKIP_WAIT ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Responses are decoded purely from registered state and holding registers.
  assign rsp_c       = (state_q == RESP);
  assign i_rsp_valid = rsp_c && (owner_q == REQ_I);
  assign d_rsp_valid = rsp_c && (owner_q == REQ_D);
  assign i_rsp_err   = i_rsp_valid && err_q;
  assign d_rsp_err   = d_rsp_valid && err_q;
  assign i_rsp_data  = i_rsp_valid ? rdata : '0;
  assign d_rsp_rdata = d_rsp_valid ? rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed requests push expected responses, a monitor checks them.
module tb_mem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid, i_req_ready;
  logic [31:0] i_req_addr;
  logic        i_rsp_valid, i_rsp_err;
  logic [31:0] i_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_we;
  logic [31:0] d_req_addr, d_req_wdata;
  logic        d_rsp_valid, d_rsp_err;
  logic [31:0] d_rsp_rdata;
`ifdef MEMRESP_BYTE_STROBE_EN
  logic [3:0]  d_req_wstrb;
`endif

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT),
    .ADDR_W      (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (i_req_valid),
    .i_req_ready (i_req_ready),
    .i_req_addr  (i_req_addr),
    .i_rsp_valid (i_rsp_valid),
    .i_rsp_data  (i_rsp_data),
    .i_rsp_err   (i_rsp_err),
    .d_req_valid (d_req_valid),
    .d_req_ready (d_req_ready),
    .d_req_we    (d_req_we),
    .d_req_addr  (d_req_addr),
    .d_req_wdata (d_req_wdata),
`ifdef MEMRESP_BYTE_STROBE_EN
    .d_req_wstrb (d_req_wstrb),
`endif
    .d_rsp_valid (d_rsp_valid),
    .d_rsp_rdata (d_rsp_rdata),
    .d_rsp_err   (d_rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every response pulse must match the oldest expectation, in the expected cycle.
  always @(negedge clk) begin
    if (i_rsp_valid === 1'b1 || d_rsp_valid === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: i_valid=%b d_valid=%b with nothing expected (cycle %0d)",
                 i_rsp_valid, d_rsp_valid, cyc);
      end else begin
        e = sb.pop_front();
        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
        if (e.is_d) begin
          chk("d_rsp_valid", 32'(d_rsp_valid), 32'd1);
          chk("d_rsp_rdata", d_rsp_rdata, e.data);
          chk("d_rsp_err", 32'(d_rsp_err), 32'(e.err));
          chk("i_port_quiet", 32'({i_rsp_valid, i_rsp_err}) | i_rsp_data, 32'd0);
        end else begin
          chk("i_rsp_valid", 32'(i_rsp_valid), 32'd1);
          chk("i_rsp_data", i_rsp_data, e.data);
          chk("i_rsp_err", 32'(i_rsp_err), 32'(e.err));
          chk("d_port_quiet", 32'({d_rsp_valid, d_rsp_err}) | d_rsp_rdata, 32'd0);
        end
      end
    end
  end

  // Present one request, hold it until accepted, optionally queue the expected response.
  task automatic issue(input bit is_d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_data,
                       input logic exp_err, input bit push, output int acc);
    int   n;
    exp_t e;
    n   = 0;
    acc = -1;
    @(negedge clk);
    if (is_d) begin
      d_req_valid = 1'b1;
      d_req_we    = we;
      d_req_addr  = addr;
      d_req_wdata = wdata;
    end else begin
      i_req_valid = 1'b1;
      i_req_addr  = addr;
    end
    while ((is_d ? d_req_ready : i_req_ready) !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: port_d=%0d addr=0x%08h never accepted", is_d, addr);
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
      if (push) begin
        e.is_d = is_d;
        e.data = exp_data;
        e.err  = exp_err;
        e.cyc  = acc + int'(LAT) - 1;
        sb.push_back(e);
      end
    end
    if (is_d) d_req_valid = 1'b0;
    else i_req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int a;
    int b;
    int n;
    rst         = 1'b1;
    i_req_valid = 1'b0;
    i_req_addr  = '0;
    d_req_valid = 1'b0;
    d_req_we    = 1'b0;
    d_req_addr  = '0;
    d_req_wdata = '0;
`ifdef MEMRESP_BYTE_STROBE_EN
    d_req_wstrb = 4'hF;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_flags", 32'({i_rsp_valid, i_rsp_err, d_rsp_valid, d_rsp_err}), 32'd0);
    chk("reset_rsp_data", i_rsp_data | d_rsp_rdata, 32'd0);
    rst = 1'b0;
    chk("idle_ready", 32'({i_req_ready, d_req_ready}), 32'd3);

    // Seed word[2], then fetch it and check the ready gap.
    issue(1'b1, 1'b1, 32'h0000_0008, 32'h1357_9BDF, 32'h0, 1'b0, 1'b1, a);
    issue(1'b0, 1'b0, 32'h0000_0008, 32'h0, 32'h1357_9BDF, 1'b0, 1'b1, a);
    @(negedge clk);
    chk("i_ready_n1", 32'(i_req_ready), 32'd0);
    @(negedge clk);
    chk("i_ready_n2", 32'(i_req_ready), 32'd0);
    @(negedge clk);
    chk("i_ready_n3", 32'(i_req_ready), 32'd1);

    // Read-after-write.
    issue(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, a);
    issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, a);

    // Simultaneous requests: data first, fetch three edges later.
    fork
      issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, a);
      issue(1'b0, 1'b0, 32'h0000_0008, 32'h0, 32'h1357_9BDF, 1'b0, 1'b1, b);
    join
    chk("fetch_after_data", 32'(b - a), 32'd3);

    // Error cases and boundaries.
    issue(1'b1, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 1'b1, 1'b1, a);
    issue(1'b1, 1'b0, 32'(DEPTH * 4), 32'h0, 32'h0, 1'b1, 1'b1, a);
    issue(1'b1, 1'b1, 32'h0000_0012, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, a);
    issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, a);
    issue(1'b1, 1'b1, 32'(DEPTH * 4), 32'h5555_5555, 32'h0, 1'b1, 1'b1, a);
    issue(1'b1, 1'b1, 32'(DEPTH * 4 - 4), 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1, a);
    issue(1'b1, 1'b0, 32'(DEPTH * 4 - 4), 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1, a);
    issue(1'b0, 1'b0, 32'h0000_0002, 32'h0, 32'h0, 1'b1, 1'b1, a);

    // Reset while a fetch is waiting: its response must never appear.
    issue(1'b0, 1'b0, 32'h0000_0008, 32'h0, 32'h0, 1'b0, 1'b0, a);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rsp_flags", 32'({i_rsp_valid, i_rsp_err, d_rsp_valid, d_rsp_err}), 32'd0);
    chk("midrst_rsp_data", i_rsp_data | d_rsp_rdata, 32'd0);
    chk("midrst_ready", 32'({i_req_ready, d_req_ready}), 32'd3);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    issue(1'b0, 1'b0, 32'h0000_0008, 32'h0, 32'h1357_9BDF, 1'b0, 1'b1, a);

`ifdef MEMRESP_BYTE_STROBE_EN
    d_req_wstrb = 4'hF;
    issue(1'b1, 1'b1, 32'h0000_0020, 32'h1122_3344, 32'h0, 1'b0, 1'b1, a);
    d_req_wstrb = 4'b0101;
    issue(1'b1, 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 32'h0, 1'b0, 1'b1, a);
    issue(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h11BB_33DD, 1'b0, 1'b1, a);
    d_req_wstrb = 4'b0000;
    issue(1'b1, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, a);
    issue(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h11BB_33DD, 1'b0, 1'b1, a);
    d_req_wstrb = 4'hF;
`endif

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the pipelined CPU's instruction-fetch and data-access ports.
- Accepts valid/ready requests from the fetch stage (read-only) and the MEM stage (read/write).
- Arbitrates between them, models a fixed access latency, and returns single-cycle response pulses.
- Word storage array is internal.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two, minimum 4
LATENCY, 2, cycles from request-accept edge to response-valid cycle; minimum 1
ADDR_W, 32, request address width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_req_valid  in  1  fetch request present
i_req_ready  out  1  responder can accept a fetch request this cycle
i_req_addr  in  ADDR_W  fetch byte address
i_rsp_valid  out  1  fetch response pulse
i_rsp_data  out  32  fetched instruction
i_rsp_err  out  1  fetch address misaligned or out of range
d_req_valid  in  1  data request present
d_req_ready  out  1  responder can accept a data request this cycle
d_req_we  in  1  1 = write, 0 = read
d_req_addr  in  ADDR_W  data byte address
d_req_wdata  in  32  write data
d_rsp_valid  out  1  data response pulse; also acknowledges writes
d_rsp_rdata  out  32  read data; 0 for writes
d_rsp_err  out  1  data address misaligned or out of range

Behaviour:
- Reset: all outputs 0, FSM in IDLE, latency counter 0, all holding registers 0. Array contents are not cleared.
- FSM states:
  - IDLE: go to WAIT on accept when LATENCY>1; go to RESP on accept when LATENCY=1; otherwise stay.
  - WAIT: counter counts LATENCY-1 cycles after the accept edge, then go to RESP.
  - RESP: one cycle, then go to IDLE.
- Only one request is outstanding at a time. Peak throughput is one request per LATENCY+1 cycles.
- Ready signals are combinational:
  - d_req_ready = (state==IDLE)
  - i_req_ready = (state==IDLE) && !d_req_valid. Data has fixed priority because it is the older instruction.
- Accept condition: valid && ready at a rising edge. Requesters must hold valid and payload stable until accepted.
- Error check at the accept edge: err if addr[1:0]!=0 or addr >= DEPTH_WORDS*4. Word index = addr[log2(DEPTH_WORDS)+1:2].
- Writes commit to the array on the accept edge. Writes with err are suppressed.
- Read data is captured into a holding register on the accept edge. Reads therefore see every write committed on an earlier edge; read-after-write returns the new data.
- Responses are presented only in RESP:
  - The owning *_rsp_valid is 1 for exactly one cycle.
  - data/err are driven from holding registers; data is 0 when err=1.
  - There is no response backpressure: the CPU must stall to absorb the response.
- The non-owning response port stays 0 in every state.
- i_rsp_data=0 on an errored fetch is intentional: the CPU halts on an all-zero instruction.
- Simultaneous i/d valid in IDLE: data is accepted, fetch waits in the next IDLE.
- A request presented during WAIT/RESP is not accepted (ready=0).
- Reset mid-operation: the pending response is dropped (no pulse) and the FSM returns to IDLE. A write already accepted remains committed.

Optional Feature:
MEMRESP_BYTE_STROBE_EN
- Defined:
  - Adds port d_req_wstrb in 4; bit k enables byte k (bits 8k+7:8k) on a write.
  - Unstrobed bytes are unchanged.
  - Strobe 4'b0000 still produces the ack with no array change.
  - Alignment rule is unchanged.
- Undefined: the port is absent and every write updates the full word.

Decomposition:
- Package mem_responder_pkg holds:
  - state enum {IDLE, WAIT, RESP}
  - requester-id constants (REQ_I, REQ_D)
  - function for the word-index/error check
- Natural sub-module: mem_responder_array. It holds the synchronous-write, capture-on-accept storage and, under the macro, the byte-lane write enables.

Test Plan:
- LATENCY=2. Fetch 0x0000_0008 accepted at cycle N -> i_rsp_valid=1 only at cycle N+2, i_rsp_data = word[2]; i_req_ready=0 at cycles N+1 and N+2.
- Write 0xDEAD_BEEF to 0x10 at cycle N, then read 0x10 once ready -> d_rsp_valid pulse at N+2 with rdata 0; read response returns 0xDEAD_BEEF, err=0.
- i_req_valid and d_req_valid both asserted in IDLE -> data served first (d_rsp_valid at N+2), fetch accepted at N+3, i_rsp_valid at N+5.
- Read at 0x0000_0006 and read at DEPTH_WORDS*4 -> d_rsp_err=1, rdata=0; a write at the misaligned address leaves the array unchanged.
- rst asserted one cycle after a fetch is accepted -> no i_rsp_valid pulse; all outputs 0 the cycle after reset; new fetch accepted normally.
- Macro defined: word 0x1122_3344, write 0xAABB_CCDD with wstrb=4'b0101 -> readback 0x11BB_33DD.
